// File: rtl/rice_core_pkg.sv
// rice_core_pkg: shared register-index type and register-file constants
package rice_core_pkg;
   localparam int RICE_CORE_NUM_GPR = 32;
   typedef logic [4:0] rice_core_rd;
endpackage

// File: rtl/rice_core_rf_scoreboard_counter.sv
// rice_core_rf_scoreboard_counter: saturating pending-write counter for one register
module rice_core_rf_scoreboard_counter #(
   parameter int MAX_PENDING = 3,
   parameter int CNT_W = $clog2(MAX_PENDING + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             inc,
   input  logic             dec,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             full,
   output logic             underflow
);
   assign busy      = count != '0;
   assign full      = count == CNT_W'(MAX_PENDING);
   assign underflow = !clr && dec && !inc && !busy;
   // count up on issue, down on write-back, hold when both, never wrap
   always_ff @(posedge i_clk)
      if (!i_rst_n || clr) count <= '0;
      else if (inc && !dec && !full) count <= count + CNT_W'(1);
      else if (dec && !inc && busy) count <= count - CNT_W'(1);
endmodule

// File: rtl/rice_core_rf_scoreboard.sv
// rice_core_rf_scoreboard: per-register pending-write tracking and issue hazard gating
module rice_core_rf_scoreboard
   import rice_core_pkg::*;
#(
   parameter int MAX_PENDING = 3
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_flush,
   input  logic                         i_issue_valid,
   output logic                         o_issue_ready,
   input  rice_core_rd                  i_issue_rs1,
   input  logic                         i_issue_rs1_used,
   input  rice_core_rd                  i_issue_rs2,
   input  logic                         i_issue_rs2_used,
   input  logic                         i_issue_rd_valid,
   input  rice_core_rd                  i_issue_rd,
   input  logic                         i_wb_valid,
   input  rice_core_rd                  i_wb_rd,
   output logic [RICE_CORE_NUM_GPR-1:0] o_busy,
   output logic                         o_wb_error
);
   localparam int CNT_W = $clog2(MAX_PENDING + 1);
   logic [CNT_W-1:0]             cnt [RICE_CORE_NUM_GPR];
   logic [RICE_CORE_NUM_GPR-1:0] busy_w, full_w, unf_w;
   logic                         fire;
   assign cnt[0]    = '0;
   assign busy_w[0] = 1'b0;
   assign full_w[0] = 1'b0;
   assign unf_w[0]  = 1'b0;
   // hazards are judged on registered counts only; a same-cycle write-back does not release
   always_comb begin
      o_issue_ready = !i_flush
         && !(i_issue_rs1_used && i_issue_rs1 != '0 && cnt[i_issue_rs1] != '0)
         && !(i_issue_rs2_used && i_issue_rs2 != '0 && cnt[i_issue_rs2] != '0)
         && !(i_issue_rd_valid && i_issue_rd != '0 && full_w[i_issue_rd]);
      fire = i_issue_valid && o_issue_ready;
   end
   for (genvar i = 1; i < RICE_CORE_NUM_GPR; i++) begin : g_cnt
      rice_core_rf_scoreboard_counter #(.MAX_PENDING(MAX_PENDING), .CNT_W(CNT_W)) u_cnt (
         .i_clk     (i_clk),
         .i_rst_n   (i_rst_n),
         .inc       (fire && i_issue_rd_valid && i_issue_rd == rice_core_rd'(i)),
         .dec       (i_wb_valid && i_wb_rd == rice_core_rd'(i)),
         .clr       (i_flush),
         .count     (cnt[i]),
         .busy      (busy_w[i]),
         .full      (full_w[i]),
         .underflow (unf_w[i])
      );
   end
   assign o_busy = busy_w;
   // sticky flag for a write-back that had nothing pending
   always_ff @(posedge i_clk)
      if (!i_rst_n) o_wb_error <= 1'b0;
      else if (!i_flush && |unf_w) o_wb_error <= 1'b1;
endmodule

// File: tb/tb_rice_core_rf_scoreboard.sv
// tb_rice_core_rf_scoreboard: scenario tests plus random traffic against a counting model
module tb_rice_core_rf_scoreboard;
   localparam int MAXP = 3;
   typedef struct packed {
      logic [31:0] busy;
      logic        err;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0, flush = 1'b0, iv = 1'b0, rdy;
   logic [4:0]  rs1 = '0, rs2 = '0, rd = '0, wbrd = '0;
   logic        rs1u = 1'b0, rs2u = 1'b0, rdv = 1'b0, wbv = 1'b0;
   logic [31:0] busy;
   logic        err;
   int          mc [32];
   bit          me;
   exp_t        sb [$];
   int          n_chk = 0, n_fail = 0;
   rice_core_rf_scoreboard #(.MAX_PENDING(MAXP)) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_flush          (flush),
      .i_issue_valid    (iv),
      .o_issue_ready    (rdy),
      .i_issue_rs1      (rs1),
      .i_issue_rs1_used (rs1u),
      .i_issue_rs2      (rs2),
      .i_issue_rs2_used (rs2u),
      .i_issue_rd_valid (rdv),
      .i_issue_rd       (rd),
      .i_wb_valid       (wbv),
      .i_wb_rd          (wbrd),
      .o_busy           (busy),
      .o_wb_error       (err)
   );
   always #5 clk = ~clk;
   function automatic bit model_ready();
      return !flush && !(rs1u && rs1 != '0 && mc[rs1] != 0)
         && !(rs2u && rs2 != '0 && mc[rs2] != 0)
         && !(rdv && rd != '0 && mc[rd] == MAXP);
   endfunction
   task automatic drv(input bit v, input logic [4:0] r1, input bit u1, input logic [4:0] r2,
                      input bit u2, input bit dv, input logic [4:0] d, input bit wv,
                      input logic [4:0] w, input bit f);
      iv = v; rs1 = r1; rs1u = u1; rs2 = r2; rs2u = u2; rdv = dv; rd = d;
      wbv = wv; wbrd = w; flush = f;
      #1;
   endtask
   task automatic step(output exp_t e);
      bit   fire;
      exp_t p;
      fire = iv && model_ready();
      if (!rst_n) begin
         foreach (mc[k]) mc[k] = 0;
         me = 1'b0;
      end else if (flush) begin
         foreach (mc[k]) mc[k] = 0;
      end else begin
         if (fire && rdv && rd != '0) mc[rd]++;
         if (wbv && wbrd != '0) begin
            if (mc[wbrd] == 0) me = 1'b1;
            else mc[wbrd]--;
         end
      end
      for (int k = 0; k < 32; k++) p.busy[k] = (k != 0) && (mc[k] != 0);
      p.err = me;
      sb.push_back(p);
      @(posedge clk);
      #1;
      e = sb.pop_front();
   endtask
   task automatic test_reset();
      exp_t e;
      rst_n = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
      step(e);
      step(e);
      rst_n = 1'b1;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_chk++; if (busy !== 32'h0) begin n_fail++; $display("FAIL reset_busy got=%h exp=%h", busy, 32'h0); end
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
      n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", rdy); end
      n_chk++; if (busy !== e.busy) begin n_fail++; $display("FAIL reset_sb got=%h exp=%h", busy, e.busy); end
   endtask
   task automatic test_raw();
      exp_t e;
      drv(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
      n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL raw_issue_rd got=%b exp=1", rdy); end
      step(e);
      n_chk++; if (busy !== e.busy || busy[5] !== 1'b1) begin n_fail++; $display("FAIL raw_busy_set got=%h exp=%h", busy, e.busy); end
      drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      n_chk++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL raw_blocked got=%b exp=0", rdy); end
      step(e);
      drv(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
      n_chk++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL raw_wb_same_cycle got=%b exp=0", rdy); end
      step(e);
      n_chk++; if (busy !== e.busy || busy[5] !== 1'b0) begin n_fail++; $display("FAIL raw_busy_clr got=%h exp=%h", busy, e.busy); end
      drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL raw_released got=%b exp=1", rdy); end
      step(e);
   endtask
   task automatic test_waw();
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         drv(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
         n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL waw_fill%0d got=%b exp=1", k, rdy); end
         step(e);
      end
      n_chk++; if (mc[7] != 3 || busy !== e.busy) begin n_fail++; $display("FAIL waw_full got=%h exp=%h", busy, e.busy); end
      drv(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
      n_chk++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL waw_sat got=%b exp=0", rdy); end
      drv(1, 0, 0, 0, 0, 1, 7, 1, 7, 0);
      n_chk++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL waw_sat_wb got=%b exp=0", rdy); end
      step(e);
      drv(1, 0, 0, 0, 0, 1, 7, 1, 7, 0);
      n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL waw_fire_wb got=%b exp=1", rdy); end
      step(e);
      drv(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
      n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL waw_cnt2 got=%b exp=1", rdy); end
      step(e);
      drv(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
      n_chk++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL waw_refull got=%b exp=0", rdy); end
      for (int k = 0; k < 3; k++) begin
         drv(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
         step(e);
      end
      n_chk++; if (busy !== 32'h0 || err !== 1'b0 || busy !== e.busy) begin n_fail++; $display("FAIL waw_drain got=%h/%b exp=%h/%b", busy, err, e.busy, e.err); end
   endtask
   task automatic test_x0();
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         drv(1, 0, 1, 0, 1, 1, 0, 0, 0, 0);
         n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL x0_ready%0d got=%b exp=1", k, rdy); end
         step(e);
         n_chk++; if (busy !== 32'h0) begin n_fail++; $display("FAIL x0_busy%0d got=%h exp=0", k, busy); end
      end
      drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      step(e);
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL x0_wb_err got=%b exp=0", err); end
   endtask
   task automatic test_flush();
      exp_t e;
      drv(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);  step(e);
      drv(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);  step(e);
      drv(1, 0, 0, 0, 0, 1, 31, 0, 0, 0); step(e);
      n_chk++; if (busy !== 32'h8000_0208) begin n_fail++; $display("FAIL flush_pre got=%h exp=%h", busy, 32'h8000_0208); end
      drv(1, 0, 0, 0, 0, 1, 4, 1, 3, 1);
      n_chk++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL flush_ready got=%b exp=0", rdy); end
      step(e);
      n_chk++; if (busy !== 32'h0 || busy !== e.busy || err !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%h/%b exp=0/0", busy, err); end
      drv(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
      n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL flush_rd4 got=%b exp=1", rdy); end
      step(e);
   endtask
   task automatic test_underflow();
      exp_t e;
      drv(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
      step(e);
      n_chk++; if (err !== 1'b1 || busy[12] !== 1'b0) begin n_fail++; $display("FAIL unf_set got=%b/%b exp=1/0", err, busy[12]); end
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) step(e);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(e);
      n_chk++; if (err !== 1'b1 || err !== e.err) begin n_fail++; $display("FAIL unf_sticky got=%b exp=1", err); end
      rst_n = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(e);
      rst_n = 1'b1;
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL unf_reset got=%b exp=0", err); end
   endtask
   task automatic test_random();
      exp_t e;
      for (int k = 0; k < 400; k++) begin
         drv(1'($urandom_range(0, 1)), 5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 4)), 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 4)),
             1'($urandom_range(0, 29) == 0));
         n_chk++; if (rdy !== model_ready()) begin n_fail++; $display("FAIL rnd_ready@%0d got=%b exp=%b", k, rdy, model_ready()); end
         step(e);
         n_chk++; if (busy !== e.busy || err !== e.err) begin n_fail++; $display("FAIL rnd_state@%0d got=%h/%b exp=%h/%b", k, busy, err, e.busy, e.err); end
      end
   endtask
   initial begin
      test_reset();
      test_raw();
      test_waw();
      test_x0();
      test_flush();
      test_underflow();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
